// File: rtl/core_sim_pkg.sv
// Shared state encoding and default parameters for the core simulation monitor.
package core_sim_pkg;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int XLEN_DEF     = 32;
  localparam int NUM_CHK_DEF  = 4;
  localparam int RST_CYC_DEF  = 2;
  localparam int HALT_CYC_DEF = 3;
  localparam int MAX_CYC_DEF  = 1000;
  localparam int CNT_W_DEF    = 16;

endpackage

// File: rtl/core_sim_monitor_if.sv
// Core-side bus seen by the monitor: PC and data-memory store snoop, plus the core reset.
interface core_sim_monitor_if
  import core_sim_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);
  logic [XLEN-1:0] pc;
  logic            dm_we;
  logic [XLEN-1:0] dm_addr;
  logic [XLEN-1:0] dm_wdata;
  logic            core_rst;

  modport master (output pc, output dm_we, output dm_addr, output dm_wdata, input core_rst);
  modport slave  (input pc, input dm_we, input dm_addr, input dm_wdata, output core_rst);
endinterface

// File: rtl/core_sim_monitor_store_snoop.sv
// Shadow registers that capture the last store to each watched address while enabled.
module store_snoop
  import core_sim_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NUM_CHK = NUM_CHK_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    dm_we,
  input  logic [XLEN-1:0]         dm_addr,
  input  logic [XLEN-1:0]         dm_wdata,
  input  logic [NUM_CHK*XLEN-1:0] chk_addr,
  output logic [NUM_CHK*XLEN-1:0] shadow
);

  logic [NUM_CHK*XLEN-1:0] shadow_r;

  // Every channel whose address matches takes the store data in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_r <= '0;
    end else begin
      for (int i = 0; i < NUM_CHK; i++) begin
        if (en && dm_we && (dm_addr == chk_addr[i*XLEN +: XLEN])) begin
          shadow_r[i*XLEN +: XLEN] <= dm_wdata;
        end
      end
    end
  end

  assign shadow = shadow_r;

endmodule

// File: rtl/core_sim_monitor.sv
// Simulation controller: holds the core in reset, runs it until halt or timeout,
// then compares snooped store signatures channel by channel.
module core_sim_monitor
  import core_sim_pkg::*;
#(
  parameter  int XLEN     = XLEN_DEF,
  parameter  int NUM_CHK  = NUM_CHK_DEF,
  parameter  int RST_CYC  = RST_CYC_DEF,
  parameter  int HALT_CYC = HALT_CYC_DEF,
  parameter  int MAX_CYC  = MAX_CYC_DEF,
  parameter  int CNT_W    = CNT_W_DEF,
  localparam int IDX_W    = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  core_sim_monitor_if.slave       core,
  input  logic [NUM_CHK*XLEN-1:0] chk_addr,
  input  logic [NUM_CHK*XLEN-1:0] chk_data,
  output logic [CNT_W-1:0]        cycle_cnt,
  output logic                    done,
  output logic                    pass,
  output logic                    fail,
  output logic                    timeout,
  output logic [IDX_W-1:0]        fail_idx
);

  state_t                  state_r, state_s;
  logic [CNT_W-1:0]        rst_cnt_r, rst_cnt_s;
  logic [CNT_W-1:0]        cycle_cnt_r, cycle_cnt_s;
  logic [CNT_W-1:0]        stable_cnt_r, stable_cnt_s, stable_inc_s;
  logic [XLEN-1:0]         pc_prev_r;
  logic [IDX_W-1:0]        idx_r, idx_s, fail_idx_r, fail_idx_s;
  logic                    done_r, done_s, pass_r, pass_s;
  logic                    fail_r, fail_s, timeout_r, timeout_s;
  logic                    core_rst_r;
  logic                    halt_s, match_s;
  logic [NUM_CHK*XLEN-1:0] shadow_s;

  store_snoop #(
    .XLEN    (XLEN),
    .NUM_CHK (NUM_CHK)
  ) u_snoop (
    .clk      (clk),
    .rst      (rst),
    .en       (state_r == RUN),
    .dm_we    (core.dm_we),
    .dm_addr  (core.dm_addr),
    .dm_wdata (core.dm_wdata),
    .chk_addr (chk_addr),
    .shadow   (shadow_s)
  );

  assign stable_inc_s = (core.pc == pc_prev_r) ? (stable_cnt_r + 1'b1) : '0;
  assign halt_s       = (stable_inc_s == CNT_W'(HALT_CYC - 1));
  assign match_s      = (shadow_s[idx_r*XLEN +: XLEN] == chk_data[idx_r*XLEN +: XLEN]);

  // Next-state and next-status logic; halt takes priority over timeout.
  always_comb begin
    state_s      = state_r;
    rst_cnt_s    = rst_cnt_r;
    cycle_cnt_s  = cycle_cnt_r;
    stable_cnt_s = '0;
    idx_s        = idx_r;
    done_s       = done_r;
    pass_s       = pass_r;
    fail_s       = fail_r;
    timeout_s    = timeout_r;
    fail_idx_s   = fail_idx_r;
    case (state_r)
      RESET: begin
        if (rst_cnt_r == CNT_W'(RST_CYC - 1)) begin
          state_s = RUN;
        end else begin
          rst_cnt_s = rst_cnt_r + 1'b1;
        end
      end
      RUN: begin
        stable_cnt_s = stable_inc_s;
        if (halt_s) begin
          state_s = CHECK;
          idx_s   = '0;
        end else if (cycle_cnt_r == CNT_W'(MAX_CYC - 1)) begin
          state_s   = DONE;
          done_s    = 1'b1;
          fail_s    = 1'b1;
          timeout_s = 1'b1;
        end else begin
          cycle_cnt_s = cycle_cnt_r + 1'b1;
        end
      end
      CHECK: begin
        if (!match_s) begin
          state_s    = DONE;
          done_s     = 1'b1;
          fail_s     = 1'b1;
          fail_idx_s = idx_r;
        end else if (idx_r == IDX_W'(NUM_CHK - 1)) begin
          state_s = DONE;
          done_s  = 1'b1;
          pass_s  = 1'b1;
        end else begin
          idx_s = idx_r + 1'b1;
        end
      end
      DONE: begin
        state_s = DONE;
      end
      default: begin
        state_s = RESET;
      end
    endcase
  end

  // State, counters and registered outputs; core reset is low only while running.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= RESET;
      rst_cnt_r    <= '0;
      cycle_cnt_r  <= '0;
      stable_cnt_r <= '0;
      pc_prev_r    <= '0;
      idx_r        <= '0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      fail_r       <= 1'b0;
      timeout_r    <= 1'b0;
      fail_idx_r   <= '0;
      core_rst_r   <= 1'b1;
    end else begin
      state_r      <= state_s;
      rst_cnt_r    <= rst_cnt_s;
      cycle_cnt_r  <= cycle_cnt_s;
      stable_cnt_r <= stable_cnt_s;
      pc_prev_r    <= core.pc;
      idx_r        <= idx_s;
      done_r       <= done_s;
      pass_r       <= pass_s;
      fail_r       <= fail_s;
      timeout_r    <= timeout_s;
      fail_idx_r   <= fail_idx_s;
      core_rst_r   <= (state_s != RUN);
    end
  end

  assign core.core_rst = core_rst_r;
  assign cycle_cnt     = cycle_cnt_r;
  assign done          = done_r;
  assign pass          = pass_r;
  assign fail          = fail_r;
  assign timeout       = timeout_r;
  assign fail_idx      = fail_idx_r;

endmodule

// File: tb/tb_core_sim_monitor.sv
// Directed bench: a stub core replays store/PC programs; a scoreboard holds the expected outcome.
module tb_core_sim_monitor;

  logic         clk;
  logic         rst;
  logic [127:0] chk_addr;
  logic [127:0] chk_data;
  logic [15:0]  cycle_cnt;
  logic         done, pass, fail, timeout;
  logic [1:0]   fail_idx;

  int n_chk;
  int n_err;

  typedef struct {
    int          e;
    logic [31:0] a;
    logic [31:0] d;
  } st_t;

  typedef struct {
    int          de;
    logic        p;
    logic        f;
    logic        t;
    logic [1:0]  fi;
    logic [15:0] cyc;
  } exp_t;

  st_t  sq[$];
  exp_t sb[$];

  core_sim_monitor_if #(.XLEN(32)) bus ();

  core_sim_monitor #(
    .XLEN(32), .NUM_CHK(4), .RST_CYC(2), .HALT_CYC(3), .MAX_CYC(50), .CNT_W(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .core      (bus),
    .chk_addr  (chk_addr),
    .chk_data  (chk_data),
    .cycle_cnt (cycle_cnt),
    .done      (done),
    .pass      (pass),
    .fail      (fail),
    .timeout   (timeout),
    .fail_idx  (fail_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_st(input int e, input logic [31:0] a, input logic [31:0] d);
    st_t s;
    s.e = e; s.a = a; s.d = d;
    sq.push_back(s);
  endtask

  task automatic add_exp(input int de, input logic p, input logic f, input logic t,
                         input logic [1:0] fi, input logic [15:0] cyc);
    exp_t x;
    x.de = de; x.p = p; x.f = f; x.t = t; x.fi = fi; x.cyc = cyc;
    sb.push_back(x);
  endtask

  task automatic set_chk(input logic [31:0] a3, a2, a1, a0, input logic [31:0] d3, d2, d1, d0);
    chk_addr = {a3, a2, a1, a0};
    chk_data = {d3, d2, d1, d0};
  endtask

  // Stub core for RUN edge k: PC walks until 'spin', then parks at hpc.
  task automatic drive_edge(input int k, input int spin, input logic [31:0] hpc);
    bus.pc       = (k <= spin) ? (32'h1000 + 32'(4 * (k - 1))) : hpc;
    bus.dm_we    = 1'b0;
    bus.dm_addr  = 32'h0;
    bus.dm_wdata = 32'h0;
    foreach (sq[i]) begin
      if (sq[i].e == k) begin
        bus.dm_we    = 1'b1;
        bus.dm_addr  = sq[i].a;
        bus.dm_wdata = sq[i].d;
      end
    end
  endtask

  task automatic do_reset(input int n_high);
    rst          = 1'b1;
    bus.pc       = 32'hFFFF_FFF0;
    bus.dm_we    = 1'b0;
    bus.dm_addr  = 32'h0;
    bus.dm_wdata = 32'h0;
    repeat (n_high) tick();
    chk("rst core_rst", bus.core_rst, 1);
    chk("rst cycle_cnt", cycle_cnt, 0);
    chk("rst done", done, 0);
    chk("rst pass", pass, 0);
    chk("rst fail", fail, 0);
    chk("rst timeout", timeout, 0);
    chk("rst fail_idx", fail_idx, 0);
    rst = 1'b0;
    tick();
    chk("hold core_rst", bus.core_rst, 1);
    chk("hold done", done, 0);
    tick();
    chk("release core_rst", bus.core_rst, 0);
  endtask

  task automatic run_test(input string tag, input int spin, input logic [31:0] hpc);
    int   de;
    exp_t x;
    de = -1;
    for (int k = 1; k <= 120 && de < 0; k++) begin
      drive_edge(k, spin, hpc);
      tick();
      if (done === 1'b1) de = k;
    end
    bus.dm_we = 1'b0;
    x = sb.pop_front();
    chk({tag, " done_edge"}, de, x.de);
    chk({tag, " pass"}, pass, x.p);
    chk({tag, " fail"}, fail, x.f);
    chk({tag, " timeout"}, timeout, x.t);
    chk({tag, " fail_idx"}, fail_idx, x.fi);
    chk({tag, " cycle_cnt"}, cycle_cnt, x.cyc);
    chk({tag, " core_rst"}, bus.core_rst, 1);
    chk({tag, " pass_and_fail"}, pass & fail, 0);
    tick();
    chk({tag, " done_sticky"}, done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    rst   = 1'b1;
    set_chk(32'hC, 32'h8, 32'h4, 32'h0, 32'h0, 32'hC, 32'h7, 32'h5);

    // Pass path: halt on edge 7, four check cycles.
    sq.delete();
    add_st(1, 32'h0, 32'h5); add_st(2, 32'h4, 32'h7); add_st(3, 32'h8, 32'hC);
    add_exp(11, 1'b1, 1'b0, 1'b0, 2'd0, 16'd6);
    do_reset(3);
    run_test("pass", 4, 32'h24);

    // Mismatch on channel 1.
    sq.delete();
    add_st(1, 32'h0, 32'h5); add_st(2, 32'h4, 32'h8); add_st(3, 32'h8, 32'hC);
    add_exp(9, 1'b0, 1'b1, 1'b0, 2'd1, 16'd6);
    do_reset(3);
    run_test("mismatch", 4, 32'h24);

    // Timeout: PC never settles.
    sq.delete();
    add_exp(50, 1'b0, 1'b1, 1'b1, 2'd0, 16'd49);
    do_reset(2);
    run_test("timeout", 1000, 32'h24);

    // Halt on the timeout cycle, store on halt cycle kept, store during CHECK dropped.
    set_chk(32'hC, 32'h8, 32'h4, 32'h0, 32'h77, 32'hC, 32'h7, 32'h5);
    sq.delete();
    add_st(1, 32'h0, 32'h5); add_st(2, 32'h4, 32'h7); add_st(3, 32'h8, 32'hC);
    add_st(50, 32'hC, 32'h77); add_st(52, 32'h8, 32'hEE);
    add_exp(54, 1'b1, 1'b0, 1'b0, 2'd0, 16'd49);
    do_reset(2);
    run_test("tie", 47, 32'h24);

    // Channels 0 and 2 watch the same address.
    set_chk(32'hC, 32'h10, 32'h4, 32'h10, 32'h0, 32'h33, 32'h7, 32'h33);
    sq.delete();
    add_st(1, 32'h10, 32'h33); add_st(2, 32'h4, 32'h7);
    add_exp(10, 1'b1, 1'b0, 1'b0, 2'd0, 16'd5);
    do_reset(2);
    run_test("dual", 3, 32'h24);

    // Reset mid-run after a store to channel 3; the rerun must see it cleared.
    set_chk(32'hC, 32'h8, 32'h4, 32'h0, 32'h0, 32'hC, 32'h7, 32'h5);
    sq.delete();
    add_st(1, 32'hC, 32'h99); add_st(2, 32'h0, 32'h5);
    do_reset(2);
    for (int k = 1; k <= 20; k++) begin
      drive_edge(k, 30, 32'h24);
      tick();
    end
    chk("midrun cycle_cnt", cycle_cnt, 20);
    chk("midrun core_rst", bus.core_rst, 0);
    do_reset(1);
    sq.delete();
    add_st(1, 32'h0, 32'h5); add_st(2, 32'h4, 32'h7); add_st(3, 32'h8, 32'hC);
    add_exp(11, 1'b1, 1'b0, 1'b0, 2'd0, 16'd6);
    run_test("rerun", 4, 32'h24);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/core_sim_monitor.md
# core_sim_monitor

Synthesizable simulation controller and result checker for the single-cycle RV32I core. It replaces hand-timed reset pulses and manual memory inspection with a fixed sequence: a parametrised reset window, then a run phase with halt detection and timeout, then a multi-channel data-memory signature check. It sits beside the core top in benches and FPGA bring-up. It drives the core reset, snoops data-memory stores, and reports done/pass/fail.

## Interface
Parameters:
- XLEN, 32, data/address width
- NUM_CHK, 4, number of signature channels (1..16)
- RST_CYC, 2, cycles core reset is held after rst falls (≥1)
- HALT_CYC, 3, consecutive cycles of unchanged PC that define halt (≥2)
- MAX_CYC, 1000, run-phase cycle limit before timeout
- CNT_W, 16, counter width; must hold MAX_CYC

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high master reset
- pc  in  XLEN  core PC
- dm_we  in  1  core data-memory write enable
- dm_addr  in  XLEN  core data-memory byte address
- dm_wdata  in  XLEN  core store data
- chk_addr  in  NUM_CHK*XLEN  per-channel watched address; channel i at bits [i*XLEN +: XLEN]
- chk_data  in  NUM_CHK*XLEN  per-channel expected final value
- core_rst  out  1  reset to the core
- cycle_cnt  out  CNT_W  run-phase cycles elapsed
- done  out  1  sticky, test finished
- pass  out  1  valid when done
- fail  out  1  valid when done
- timeout  out  1  valid when done
- fail_idx  out  $clog2(NUM_CHK) (min 1)  first mismatching channel

## Operation
- FSM states: RESET, RUN, CHECK, DONE.
- RESET:
  - core_rst=1.
  - rst_cnt counts cycles with rst low.
  - After RST_CYC such cycles, go to RUN.
- RUN:
  - core_rst=0; cycle_cnt increments each cycle.
  - pc_prev is registered each cycle. stable_cnt increments when pc==pc_prev and clears otherwise.
  - Halt: stable_cnt reaches HALT_CYC-1, i.e. the PC has been unchanged over HALT_CYC consecutive samples. Next state is CHECK.
  - Timeout: cycle_cnt reaches MAX_CYC-1 without halt. Next state is DONE with timeout=1, fail=1.
  - Halt and timeout in the same cycle: halt wins.
- Store snoop, RUN only:
  - When dm_we=1 and dm_addr==chk_addr[i], shadow[i] takes dm_wdata.
  - All matching channels update in the same cycle.
  - Stores in other states are ignored.
  - Shadows reset to 0, so an unwritten channel compares as 0.
- CHECK:
  - core_rst=1 to freeze the core.
  - idx goes 0..NUM_CHK-1, one channel per cycle. Compare shadow[idx] with chk_data[idx].
  - First mismatch: DONE with fail=1, fail_idx=idx.
  - All channels match: DONE with pass=1.
- DONE: core_rst=1; all status outputs hold until rst.
- rst=1 in any state, mid-run included: next cycle is RESET, all registers at reset values.

## Timing
- Reset values:
  - core_rst=1
  - cycle_cnt=0, done=0, pass=0, fail=0, timeout=0, fail_idx=0
  - shadows=0, rst_cnt=0, stable_cnt=0
- Release: rst falls before edge N. core_rst goes low after edge N+RST_CYC-1, so the first core execution cycle follows edge N+RST_CYC.
- Outputs are registered; there is no combinational input-to-output path.
- A store on the halt-detect cycle is captured.
- Check latency: NUM_CHK cycles worst case from entering CHECK to done=1. With a mismatch at channel k, latency is k+1 cycles.
- pass and fail are never both 1. timeout=1 implies fail=1.
- cycle_cnt freezes on leaving RUN.

## Structure
- Shared package/header core_sim_pkg holds:
  - state encoding: RESET=2'd0, RUN=2'd1, CHECK=2'd2, DONE=2'd3
  - the default parameter constants
- One sub-module, store_snoop: NUM_CHK shadow registers with address-match capture. Parameters XLEN and NUM_CHK; ports clk, rst, en, dm_we, dm_addr, dm_wdata, chk_addr, shadow bus.
- The top holds the FSM, counters, halt detector and sequential comparator.

## Test plan
- Reset window: RST_CYC=2, rst high for 3 cycles then low → core_rst low exactly 2 edges later; all outputs 0 before that.
- Pass path:
  - Stub core stores 0x5 to 0x0, 0x7 to 0x4, 0xC to 0x8, then holds pc=0x24.
  - chk = {0x0:5, 0x4:7, 0x8:C, 0xC:0}.
  - Expect done=1, pass=1 exactly HALT_CYC-1 (halt detect) + 4 (check) cycles after pc settles.
- Mismatch: same run but 0x4 receives 0x8 → fail=1, fail_idx=1, pass=0, done 2 cycles after entering CHECK.
- Timeout: MAX_CYC=50, pc increments by 4 forever → done=1, timeout=1, fail=1, cycle_cnt=49.
- Boundaries:
  - Halt and timeout on the same cycle → CHECK entered, timeout=0.
  - Store to an address watched by channels 0 and 2 → both shadows updated.
  - Store during CHECK → ignored.
- Reset mid-run: assert rst at cycle 20 of RUN → core_rst=1, cycle_cnt=0, shadows cleared next cycle; a full rerun then passes.
